// File: rtl/array_heap_pkg.sv
// array_heap_pkg: shared action codes, error codes, FSM state type and
// action classification helpers for the array heap.
package array_heap_pkg;

  localparam logic [7:0] ACT_RESET    = 8'd1;
  localparam logic [7:0] ACT_WRITE    = 8'd2;
  localparam logic [7:0] ACT_READ     = 8'd3;
  localparam logic [7:0] ACT_SIZE     = 8'd4;
  localparam logic [7:0] ACT_INDEX    = 8'd7;
  localparam logic [7:0] ACT_LESS     = 8'd8;
  localparam logic [7:0] ACT_GREATER  = 8'd9;
  localparam logic [7:0] ACT_PUSH     = 8'd14;
  localparam logic [7:0] ACT_POP      = 8'd15;
  localparam logic [7:0] ACT_RESIZE   = 8'd17;
  localparam logic [7:0] ACT_ALLOC    = 8'd18;
  localparam logic [7:0] ACT_FREE     = 8'd19;
  localparam logic [7:0] ACT_ADD      = 8'd20;
  localparam logic [7:0] ACT_SUBTRACT = 8'd22;

  localparam logic [31:0] ERR_NONE        = 32'd0;
  localparam logic [31:0] ERR_BAD_ACTION  = 32'd1;
  localparam logic [31:0] ERR_UNALLOC     = 32'd2;
  localparam logic [31:0] ERR_INDEX       = 32'd3;
  localparam logic [31:0] ERR_OVERFLOW    = 32'd4;
  localparam logic [31:0] ERR_UNDERFLOW   = 32'd5;
  localparam logic [31:0] ERR_DOUBLE_FREE = 32'd6;
  localparam logic [31:0] ERR_NO_FREE     = 32'd7;
  localparam logic [31:0] ERR_NOT_FOUND   = 32'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_SCAN = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  function automatic logic is_scan(input logic [7:0] a);
    return (a == ACT_LESS) || (a == ACT_GREATER) || (a == ACT_INDEX);
  endfunction

  function automatic logic is_known(input logic [7:0] a);
    case (a)
      ACT_RESET, ACT_WRITE, ACT_READ, ACT_SIZE, ACT_INDEX, ACT_LESS,
      ACT_GREATER, ACT_PUSH, ACT_POP, ACT_RESIZE, ACT_ALLOC, ACT_FREE,
      ACT_ADD, ACT_SUBTRACT: return 1'b1;
      default:               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/array_heap_freelist.sv
// array_heap_freelist: allocation bit per array, lowest-free priority
// encoder and full flag.
//  clock, reset       : clock, synchronous active-high reset (all free)
//  clear_i            : mark every array free
//  set_i/set_idx_i    : mark one array allocated
//  free_i/free_idx_i  : mark one array free
//  alloc_o            : allocation vector (1 = in use)
//  lowest_o           : lowest-numbered free array (0 when full)
//  full_o             : every array in use
module array_heap_freelist #(
  parameter int ARRAYS = 4,
  parameter int IDX_W  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              set_i,
  input  logic [IDX_W-1:0]  set_idx_i,
  input  logic              free_i,
  input  logic [IDX_W-1:0]  free_idx_i,
  output logic [ARRAYS-1:0] alloc_o,
  output logic [IDX_W-1:0]  lowest_o,
  output logic              full_o
);

  logic [ARRAYS-1:0] alloc_q;

  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      alloc_q <= '0;
    end else begin
      if (set_i)  alloc_q[set_idx_i]  <= 1'b1;
      if (free_i) alloc_q[free_idx_i] <= 1'b0;
    end
  end

  // Walk from the top down so the lowest free index is the last one written.
  always_comb begin
    lowest_o = '0;
    for (int unsigned i = ARRAYS; i > 0; i--) begin
      if (!alloc_q[i-1]) lowest_o = IDX_W'(i - 1);
    end
  end

  assign alloc_o = alloc_q;
  assign full_o  = &alloc_q;

endmodule

// File: rtl/array_heap.sv
// array_heap: heap of fixed-length arrays behind a request/response handshake.
//  clock, reset          : clock, synchronous active-high reset
//  req_valid/req_ready   : request handshake (ready only when idle)
//  req_action            : action code (array_heap_pkg)
//  req_array/req_index   : array number / element index
//  req_in                : input data
//  rsp_valid             : one-cycle response pulse
//  rsp_out/rsp_error     : result data / error code (held until next response)
module array_heap
  import array_heap_pkg::*;
#(
  parameter int ADDRESS_BITS = 2,
  parameter int INDEX_BITS   = 1,
  parameter int DATA_BITS    = 12
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [7:0]              req_action,
  input  logic [ADDRESS_BITS-1:0] req_array,
  input  logic [INDEX_BITS-1:0]   req_index,
  input  logic [DATA_BITS-1:0]    req_in,
  output logic                    rsp_valid,
  output logic [DATA_BITS-1:0]    rsp_out,
  output logic [31:0]             rsp_error
);

  localparam int ARRAYS = 2 ** ADDRESS_BITS;
  localparam int LEN    = 2 ** INDEX_BITS;
  localparam int SW     = INDEX_BITS + 1;
  localparam int AW     = ADDRESS_BITS + INDEX_BITS;

  state_e                  state_q, state_d;
  logic [7:0]              act_q;
  logic [ADDRESS_BITS-1:0] arr_q;
  logic [INDEX_BITS-1:0]   idx_q;
  logic [DATA_BITS-1:0]    in_q;
  logic [SW-1:0]           scan_i_q, cnt_q;
  logic                    found_q;
  logic [INDEX_BITS-1:0]   fidx_q;
  logic [DATA_BITS-1:0]    out_q, out_d;
  logic [31:0]             err_q, err_d;
  logic [SW-1:0]           sizes_q [ARRAYS];
  logic [DATA_BITS-1:0]    mem_q   [ARRAYS*LEN];

  logic [ARRAYS-1:0]       alloc;
  logic [ADDRESS_BITS-1:0] lowest;
  logic                    full;
  logic [SW-1:0]           cur_size, size_m1;
  logic [INDEX_BITS-1:0]   elem_sel;
  logic [AW-1:0]           addr;
  logic [DATA_BITS-1:0]    elem;
  logic                    exec;
  logic                    mem_we, size_we, sizes_clr, fl_clear, fl_set, fl_free;
  logic [DATA_BITS-1:0]    mem_wdata;
  logic [ADDRESS_BITS-1:0] size_widx;
  logic [SW-1:0]           size_wdata;

  array_heap_freelist #(
    .ARRAYS (ARRAYS),
    .IDX_W  (ADDRESS_BITS)
  ) u_freelist (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (fl_clear),
    .set_i      (fl_set),
    .set_idx_i  (lowest),
    .free_i     (fl_free),
    .free_idx_i (arr_q),
    .alloc_o    (alloc),
    .lowest_o   (lowest),
    .full_o     (full)
  );

  assign cur_size = sizes_q[arr_q];
  assign size_m1  = cur_size - SW'(1);
  assign exec     = (state_q == ST_EXEC) && !reset;

  always_comb begin
    elem_sel = idx_q;
    if (state_q == ST_SCAN)     elem_sel = scan_i_q[INDEX_BITS-1:0];
    else if (act_q == ACT_PUSH) elem_sel = cur_size[INDEX_BITS-1:0];
    else if (act_q == ACT_POP)  elem_sel = size_m1[INDEX_BITS-1:0];
  end

  assign addr = {arr_q, elem_sel};
  assign elem = mem_q[addr];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = is_scan(req_action) ? ST_SCAN : ST_EXEC;
      ST_SCAN: if (scan_i_q == SW'(LEN - 1)) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      default: state_d = ST_IDLE;
    endcase
  end

  // Error checks in priority order; only an error-free request commits state.
  always_comb begin
    err_d      = ERR_NONE;
    out_d      = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    size_we    = 1'b0;
    size_widx  = arr_q;
    size_wdata = '0;
    sizes_clr  = 1'b0;
    fl_clear   = 1'b0;
    fl_set     = 1'b0;
    fl_free    = 1'b0;
    if (!is_known(act_q)) begin
      err_d = ERR_BAD_ACTION;
    end else if (act_q != ACT_RESET && act_q != ACT_ALLOC && act_q != ACT_FREE
                 && !alloc[arr_q]) begin
      err_d = ERR_UNALLOC;
    end else if ((act_q == ACT_READ || act_q == ACT_WRITE || act_q == ACT_ADD ||
                  act_q == ACT_SUBTRACT) && ({1'b0, idx_q} >= cur_size)) begin
      err_d = ERR_INDEX;
    end else if (act_q == ACT_RESIZE && in_q > DATA_BITS'(LEN)) begin
      err_d = ERR_INDEX;
    end else if (act_q == ACT_PUSH && cur_size == SW'(LEN)) begin
      err_d = ERR_OVERFLOW;
    end else if (act_q == ACT_POP && cur_size == '0) begin
      err_d = ERR_UNDERFLOW;
    end else if (act_q == ACT_FREE && !alloc[arr_q]) begin
      err_d = ERR_DOUBLE_FREE;
    end else if (act_q == ACT_ALLOC && full) begin
      err_d = ERR_NO_FREE;
    end else if (act_q == ACT_INDEX && !found_q) begin
      err_d = ERR_NOT_FOUND;
    end else begin
      case (act_q)
        ACT_RESET:   begin sizes_clr = exec; fl_clear = exec; end
        ACT_ALLOC:   begin
          out_d     = DATA_BITS'(lowest);
          fl_set    = exec;
          size_we   = exec;
          size_widx = lowest;
        end
        ACT_FREE:    fl_free = exec;
        ACT_WRITE:   begin mem_we = exec; mem_wdata = in_q; end
        ACT_READ:    out_d = elem;
        ACT_SIZE:    out_d = DATA_BITS'(cur_size);
        ACT_RESIZE:  begin size_we = exec; size_wdata = in_q[SW-1:0]; end
        ACT_PUSH:    begin
          mem_we     = exec;
          mem_wdata  = in_q;
          size_we    = exec;
          size_wdata = cur_size + SW'(1);
        end
        ACT_POP:     begin out_d = elem; size_we = exec; size_wdata = size_m1; end
        ACT_ADD:     begin mem_we = exec; mem_wdata = elem + in_q; out_d = elem + in_q; end
        ACT_SUBTRACT: begin mem_we = exec; mem_wdata = elem - in_q; out_d = elem - in_q; end
        ACT_LESS, ACT_GREATER: out_d = DATA_BITS'(cnt_q);
        ACT_INDEX:   out_d = DATA_BITS'(fidx_q);
        default:     out_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      act_q    <= '0;
      arr_q    <= '0;
      idx_q    <= '0;
      in_q     <= '0;
      scan_i_q <= '0;
      cnt_q    <= '0;
      found_q  <= 1'b0;
      fidx_q   <= '0;
      out_q    <= '0;
      err_q    <= ERR_NONE;
      for (int unsigned i = 0; i < ARRAYS; i++) sizes_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (req_valid) begin
          act_q    <= req_action;
          arr_q    <= req_array;
          idx_q    <= req_index;
          in_q     <= req_in;
          scan_i_q <= '0;
          cnt_q    <= '0;
          found_q  <= 1'b0;
          fidx_q   <= '0;
        end
        ST_SCAN: begin
          if (scan_i_q < cur_size) begin
            if ((act_q == ACT_LESS && elem < in_q) ||
                (act_q == ACT_GREATER && elem > in_q)) cnt_q <= cnt_q + SW'(1);
            if (act_q == ACT_INDEX && !found_q && elem == in_q) begin
              found_q <= 1'b1;
              fidx_q  <= scan_i_q[INDEX_BITS-1:0];
            end
          end
          scan_i_q <= scan_i_q + SW'(1);
        end
        ST_EXEC: begin
          out_q <= out_d;
          err_q <= err_d;
          if (sizes_clr) begin
            for (int unsigned i = 0; i < ARRAYS; i++) sizes_q[i] <= '0;
          end else if (size_we) begin
            sizes_q[size_widx] <= size_wdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Element storage is deliberately not cleared by reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[addr] <= mem_wdata;
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_out   = out_q;
  assign rsp_error = err_q;

endmodule

// File: tb/tb_array_heap.sv
module tb_array_heap;

  localparam logic [7:0] A_RESET = 8'd1,  A_WRITE = 8'd2,  A_READ = 8'd3,
                         A_SIZE  = 8'd4,  A_INDEX = 8'd7,  A_LESS = 8'd8,
                         A_GREATER = 8'd9, A_PUSH = 8'd14, A_POP = 8'd15,
                         A_RESIZE = 8'd17, A_ALLOC = 8'd18, A_FREE = 8'd19,
                         A_ADD = 8'd20, A_SUB = 8'd22;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_action = '0;
  logic [1:0]  req_array = '0;
  logic [0:0]  req_index = '0;
  logic [11:0] req_in = '0;
  logic        rsp_valid;
  logic [11:0] rsp_out;
  logic [31:0] rsp_error;

  int checks = 0;
  int errors = 0;

  logic [11:0] o;
  logic [31:0] e;
  int          lat;

  array_heap #(
    .ADDRESS_BITS (2),
    .INDEX_BITS   (1),
    .DATA_BITS    (12)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_action (req_action),
    .req_array  (req_array),
    .req_index  (req_index),
    .req_in     (req_in),
    .rsp_valid  (rsp_valid),
    .rsp_out    (rsp_out),
    .rsp_error  (rsp_error)
  );

  always #5 clock = ~clock;

  // Latency is the number of rising edges after the accepting edge up to and
  // including the first edge that sees rsp_valid high.
  task automatic do_req(input logic [7:0] a, input logic [1:0] arr,
                        input logic [0:0] idx, input logic [11:0] din,
                        output logic [11:0] ro, output logic [31:0] re,
                        output int rlat);
    int w;
    @(negedge clock);
    req_valid = 1'b1; req_action = a; req_array = arr; req_index = idx; req_in = din;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clock); w++; end
    @(posedge clock);
    rlat = 0;
    do begin
      @(negedge clock);
      req_valid = 1'b0;
      rlat++;
    end while (!rsp_valid && rlat < 20);
    checks++;
    if (!rsp_valid) begin
      errors++;
      $display("FAIL timeout action=%0d: no rsp_valid within %0d cycles", a, rlat);
    end
    ro = rsp_out;
    re = rsp_error;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({req_ready, rsp_valid, rsp_out, rsp_error} !== {1'b1, 1'b0, 12'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_state: ready=%0b valid=%0b out=%0h err=%0d expected 1 0 0 0",
               req_ready, rsp_valid, rsp_out, rsp_error);
    end
  endtask

  task automatic test_alloc();
    do_req(A_RESET, 0, 0, 0, o, e, lat);
    for (int i = 0; i < 4; i++) begin
      do_req(A_ALLOC, 0, 0, 0, o, e, lat);
      checks++;
      if (o !== 12'(i) || e !== 32'd0 || lat !== 2) begin
        errors++;
        $display("FAIL alloc%0d: out=%0d err=%0d lat=%0d expected out=%0d err=0 lat=2", i, o, e, lat, i);
      end
    end
    do_req(A_ALLOC, 0, 0, 0, o, e, lat);
    checks++;
    if (o !== 12'd0 || e !== 32'd7) begin
      errors++;
      $display("FAIL alloc_full: out=%0d err=%0d expected out=0 err=7", o, e);
    end
  endtask

  task automatic test_push_pop();
    do_req(A_RESET, 0, 0, 0, o, e, lat);
    do_req(A_ALLOC, 0, 0, 0, o, e, lat);
    checks++;
    if (o !== 12'd0 || e !== 32'd0) begin
      errors++; $display("FAIL pp_alloc: out=%0d err=%0d expected out=0 err=0", o, e);
    end
    do_req(A_PUSH, 0, 0, 12'd5, o, e, lat);
    do_req(A_PUSH, 0, 0, 12'd9, o, e, lat);
    checks++;
    if (e !== 32'd0) begin errors++; $display("FAIL push9: err=%0d expected 0", e); end
    do_req(A_SIZE, 0, 0, 0, o, e, lat);
    checks++;
    if (o !== 12'd2 || e !== 32'd0) begin
      errors++; $display("FAIL size2: out=%0d err=%0d expected out=2 err=0", o, e);
    end
    do_req(A_PUSH, 0, 0, 12'd7, o, e, lat);
    checks++;
    if (o !== 12'd0 || e !== 32'd4) begin
      errors++; $display("FAIL overflow: out=%0d err=%0d expected out=0 err=4", o, e);
    end
    do_req(A_POP, 0, 0, 0, o, e, lat);
    checks++;
    if (o !== 12'd9 || e !== 32'd0) begin
      errors++; $display("FAIL pop9: out=%0d err=%0d expected out=9 err=0", o, e);
    end
    do_req(A_POP, 0, 0, 0, o, e, lat);
    checks++;
    if (o !== 12'd5 || e !== 32'd0) begin
      errors++; $display("FAIL pop5: out=%0d err=%0d expected out=5 err=0", o, e);
    end
    do_req(A_POP, 0, 0, 0, o, e, lat);
    checks++;
    if (o !== 12'd0 || e !== 32'd5) begin
      errors++; $display("FAIL underflow: out=%0d err=%0d expected out=0 err=5", o, e);
    end
  endtask

  task automatic test_scan();
    do_req(A_PUSH, 0, 0, 12'd5, o, e, lat);
    do_req(A_PUSH, 0, 0, 12'd9, o, e, lat);
    do_req(A_GREATER, 0, 0, 12'd6, o, e, lat);
    checks++;
    if (o !== 12'd1 || e !== 32'd0 || lat !== 4) begin
      errors++; $display("FAIL greater6: out=%0d err=%0d lat=%0d expected out=1 err=0 lat=4", o, e, lat);
    end
    do_req(A_LESS, 0, 0, 12'd6, o, e, lat);
    checks++;
    if (o !== 12'd1 || e !== 32'd0) begin
      errors++; $display("FAIL less6: out=%0d err=%0d expected out=1 err=0", o, e);
    end
    do_req(A_LESS, 0, 0, 12'd10, o, e, lat);
    checks++;
    if (o !== 12'd2 || e !== 32'd0) begin
      errors++; $display("FAIL less10: out=%0d err=%0d expected out=2 err=0", o, e);
    end
    do_req(A_INDEX, 0, 0, 12'd9, o, e, lat);
    checks++;
    if (o !== 12'd1 || e !== 32'd0) begin
      errors++; $display("FAIL index9: out=%0d err=%0d expected out=1 err=0", o, e);
    end
    do_req(A_INDEX, 0, 0, 12'd7, o, e, lat);
    checks++;
    if (o !== 12'd0 || e !== 32'd8) begin
      errors++; $display("FAIL index7: out=%0d err=%0d expected out=0 err=8", o, e);
    end
  endtask

  task automatic test_arith();
    do_req(A_WRITE, 0, 0, 12'hFFF, o, e, lat);
    do_req(A_ADD, 0, 0, 12'd2, o, e, lat);
    checks++;
    if (o !== 12'h001 || e !== 32'd0) begin
      errors++; $display("FAIL add_wrap: out=%0h err=%0d expected out=1 err=0", o, e);
    end
    do_req(A_SUB, 0, 0, 12'd3, o, e, lat);
    checks++;
    if (o !== 12'hFFE || e !== 32'd0) begin
      errors++; $display("FAIL sub_wrap: out=%0h err=%0d expected out=ffe err=0", o, e);
    end
    do_req(A_READ, 0, 0, 0, o, e, lat);
    checks++;
    if (o !== 12'hFFE || e !== 32'd0) begin
      errors++; $display("FAIL read0: out=%0h err=%0d expected out=ffe err=0", o, e);
    end
    do_req(A_RESIZE, 0, 0, 12'd1, o, e, lat);
    do_req(A_READ, 0, 1, 0, o, e, lat);
    checks++;
    if (o !== 12'd0 || e !== 32'd3) begin
      errors++; $display("FAIL read_oob: out=%0h err=%0d expected out=0 err=3", o, e);
    end
    do_req(A_RESIZE, 0, 0, 12'd3, o, e, lat);
    checks++;
    if (e !== 32'd3) begin errors++; $display("FAIL resize3: err=%0d expected 3", e); end
    do_req(A_RESIZE, 0, 0, 12'd2, o, e, lat);
    do_req(A_READ, 0, 1, 0, o, e, lat);
    checks++;
    if (o !== 12'd9 || e !== 32'd0) begin
      errors++; $display("FAIL read1_after_resize: out=%0h err=%0d expected out=9 err=0", o, e);
    end
    do_req(8'd99, 0, 0, 0, o, e, lat);
    checks++;
    if (o !== 12'd0 || e !== 32'd1) begin
      errors++; $display("FAIL bad_action: out=%0h err=%0d expected out=0 err=1", o, e);
    end
  endtask

  task automatic test_free();
    do_req(A_ALLOC, 0, 0, 0, o, e, lat);
    checks++;
    if (o !== 12'd1 || e !== 32'd0) begin
      errors++; $display("FAIL alloc_a1: out=%0d err=%0d expected out=1 err=0", o, e);
    end
    do_req(A_FREE, 1, 0, 0, o, e, lat);
    checks++;
    if (o !== 12'd0 || e !== 32'd0) begin
      errors++; $display("FAIL free_a1: out=%0d err=%0d expected out=0 err=0", o, e);
    end
    do_req(A_FREE, 1, 0, 0, o, e, lat);
    checks++;
    if (o !== 12'd0 || e !== 32'd6) begin
      errors++; $display("FAIL double_free: out=%0d err=%0d expected out=0 err=6", o, e);
    end
    do_req(A_READ, 1, 0, 0, o, e, lat);
    checks++;
    if (o !== 12'd0 || e !== 32'd2) begin
      errors++; $display("FAIL read_unalloc: out=%0d err=%0d expected out=0 err=2", o, e);
    end
    do_req(A_ALLOC, 0, 0, 0, o, e, lat);
    checks++;
    if (o !== 12'd1 || e !== 32'd0) begin
      errors++; $display("FAIL realloc_a1: out=%0d err=%0d expected out=1 err=0", o, e);
    end
  endtask

  task automatic test_reset_scan();
    int seen;
    seen = 0;
    @(negedge clock);
    req_valid = 1'b1; req_action = A_GREATER; req_array = 2'd0; req_index = '0; req_in = 12'd6;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    if (rsp_valid) seen++;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({req_ready, rsp_valid, rsp_out, rsp_error} !== {1'b1, 1'b0, 12'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_mid_scan: ready=%0b valid=%0b out=%0h err=%0d expected 1 0 0 0",
               req_ready, rsp_valid, rsp_out, rsp_error);
    end
    repeat (6) begin @(negedge clock); if (rsp_valid) seen++; end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL aborted_scan_rsp: pulses=%0d expected 0", seen);
    end
    do_req(A_ALLOC, 0, 0, 0, o, e, lat);
    checks++;
    if (o !== 12'd0 || e !== 32'd0) begin
      errors++; $display("FAIL alloc_after_reset: out=%0d err=%0d expected out=0 err=0", o, e);
    end
    do_req(A_SIZE, 1, 0, 0, o, e, lat);
    checks++;
    if (o !== 12'd0 || e !== 32'd2) begin
      errors++; $display("FAIL a1_free_after_reset: out=%0d err=%0d expected out=0 err=2", o, e);
    end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_push_pop();
    test_scan();
    test_arith();
    test_free();
    test_reset_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
